// File: rtl/spi_flash_target_pkg.sv
// Shared opcodes and state encoding for the SPI flash target.
package spi_flash_target_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_STATUS,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rising/falling edge detect on the
// synchronized level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= {3{RESET_VAL}};
    else       sync <= {sync[1:0], din};
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~sync[2];
  assign fall  = ~sync[1] & sync[2];

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash target with backdoor read port.
// Define SPI_FLASH_TARGET_RDSR_EN to enable the RDSR (0x05) status command.
module spi_flash_target #(
  parameter int FLASH_ADDR_SZ = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_clk,
  input  logic                     spi_cs,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [FLASH_ADDR_SZ-1:0] bd_addr,
  output logic [7:0]               bd_dout,
  output logic                     wel
);
  import spi_flash_target_pkg::*;

  localparam int DEPTH = 1 << FLASH_ADDR_SZ;
  localparam logic [FLASH_ADDR_SZ-1:0] PTR_ONE = 1;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .din(spi_clk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .din(spi_cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [7:0] addr_hi;
  logic [7:0] op;
  logic [7:0] tx;
  logic [FLASH_ADDR_SZ-1:0] ptr;
  logic extra;
  logic armed;
  logic [1:0] hi_cnt;

  logic [7:0] mem [DEPTH];

  logic [7:0]  sr_next;
  logic        byte_done;
  logic [15:0] addr_full;
  logic [FLASH_ADDR_SZ-1:0] addr_ptr;
  logic [FLASH_ADDR_SZ-1:0] rd_addr;
  logic [7:0]  rd_data;
  logic        mem_we;
  logic        unused_bits;

  assign sr_next   = {sr[6:0], mosi_lvl};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign addr_full = {addr_hi, sr_next};
  assign addr_ptr  = addr_full[FLASH_ADDR_SZ-1:0];
  assign rd_addr   = (state == ST_ADDR_LO) ? addr_ptr : ptr;
  assign rd_data   = mem[rd_addr];
  assign mem_we    = !reset && !cs_lvl && wel &&
                     (state == ST_DATA_WR) && byte_done;

  assign unused_bits = ^{sclk_lvl, mosi_rise, mosi_fall,
                         addr_full, OP_RDSR};

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= sr_next;
  end

  always_ff @(posedge clk) begin
    if (reset) bd_dout <= 8'h00;
    else       bd_dout <= mem[bd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      sr       <= 8'h00;
      addr_hi  <= 8'h00;
      op       <= 8'h00;
      tx       <= 8'h00;
      ptr      <= '0;
      extra    <= 1'b0;
      spi_miso <= 1'b0;
      wel      <= 1'b0;
      armed    <= 1'b0;
      hi_cnt   <= 2'd0;
    end else begin
      // Chip select must read high past the reset-seeded sync values
      // before a falling edge may start a transaction.
      if (!armed) begin
        hi_cnt <= cs_lvl ? hi_cnt + 2'd1 : 2'd0;
        armed  <= cs_lvl && (hi_cnt == 2'd2);
      end
      if (cs_lvl) begin
        state    <= ST_IDLE;
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b0;
        if (cs_rise) begin
          if (state == ST_IGNORE && !extra && op == OP_WREN)
            wel <= 1'b1;
          if (state == ST_IGNORE && !extra && op == OP_WRDI)
            wel <= 1'b0;
          if (op == OP_WRITE &&
              (state == ST_ADDR_HI || state == ST_ADDR_LO ||
               state == ST_DATA_WR))
            wel <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          sr      <= sr_next;
        end
        unique case (state)
          ST_IDLE: begin
            if (cs_fall && armed) begin
              state   <= ST_CMD;
              bit_cnt <= 3'd0;
              extra   <= 1'b0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              op <= sr_next;
              case (sr_next)
                OP_READ, OP_WRITE: state <= ST_ADDR_HI;
`ifdef SPI_FLASH_TARGET_RDSR_EN
                OP_RDSR: begin
                  state <= ST_STATUS;
                  tx    <= {6'b0, wel, 1'b0};
                end
`endif
                default: state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR_HI: begin
            if (byte_done) begin
              addr_hi <= sr_next;
              state   <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (byte_done) begin
              if (op == OP_READ) begin
                state <= ST_DATA_RD;
                tx    <= rd_data;
                ptr   <= addr_ptr + PTR_ONE;
              end else begin
                state <= ST_DATA_WR;
                ptr   <= addr_ptr;
              end
            end
          end
          ST_DATA_RD: begin
            if (sclk_fall) begin
              spi_miso <= tx[7];
              tx       <= {tx[6:0], 1'b0};
            end
            if (byte_done) begin
              tx  <= rd_data;
              ptr <= ptr + PTR_ONE;
            end
          end
          ST_DATA_WR: begin
            if (byte_done) ptr <= ptr + PTR_ONE;
          end
          ST_STATUS: begin
`ifdef SPI_FLASH_TARGET_RDSR_EN
            if (sclk_fall) begin
              spi_miso <= tx[7];
              tx       <= {tx[6:0], 1'b0};
            end
            if (byte_done) tx <= {6'b0, wel, 1'b0};
`else
            state <= ST_IGNORE;
`endif
          end
          ST_IGNORE: begin
            if (sclk_rise) extra <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_target.sv
// Randomized self-checking bench for spi_flash_target against a
// transaction-level model of the flash array, WEL latch and MISO stream.
module tb_spi_flash_target;

  localparam int AW     = 11;
  localparam int DEPTH  = 1 << AW;
  localparam int HALF   = 40;
  localparam int CS_GAP = 200;

  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_READ  = 8'h03;
  localparam logic [7:0] C_WRDI  = 8'h04;
  localparam logic [7:0] C_RDSR  = 8'h05;
  localparam logic [7:0] C_WREN  = 8'h06;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0] bd_dout;
  logic wel;

  always #5 clk = ~clk;

  spi_flash_target #(.FLASH_ADDR_SZ(AW)) dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .bd_addr(bd_addr), .bd_dout(bd_dout), .wel(wel)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic       m_wel;

  logic tx_bits [512];
  logic rx_bits [512];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic put_byte(input int pos, input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_bits[pos+i] = v[7-i];
  endtask

  task automatic put_hdr(input logic [7:0] op, input logic [15:0] a);
    put_byte(0, op);
    put_byte(8, a[15:8]);
    put_byte(16, a[7:0]);
  endtask

  function automatic logic [7:0] rx_byte(input int pos);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], rx_bits[pos+i]};
    return v;
  endfunction

  task automatic spi_txn(input int nbits, input bit keep_cs);
    spi_cs = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx_bits[i];
      #(HALF);
      spi_clk = 1'b1;
      rx_bits[i] = spi_miso;
      #(HALF);
      spi_clk = 1'b0;
    end
    if (!keep_cs) begin
      #(HALF);
      spi_cs = 1'b1;
      #(CS_GAP);
    end
  endtask

  // Expected MISO per bit and state effects, from the command semantics.
  task automatic model_txn(input int nbits);
    logic [7:0] op, st, d;
    logic [15:0] a16;
    int base, a, nb;
    logic e;
    bit care;
    op = 8'h00;
    a16 = 16'h0000;
    if (nbits >= 8)
      for (int i = 0; i < 8; i++) op = {op[6:0], tx_bits[i]};
    if (nbits >= 24)
      for (int i = 8; i < 24; i++) a16 = {a16[14:0], tx_bits[i]};
    base = int'(a16) % DEPTH;
    st = {6'b0, m_wel, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      e = 1'b0;
      care = 1'b1;
      if (nbits >= 8 && op == C_READ && i >= 24) begin
        a = (base + (i - 24) / 8) % DEPTH;
        care = m_known[a];
        e = m_mem[a][7 - (i - 24) % 8];
      end
`ifdef SPI_FLASH_TARGET_RDSR_EN
      else if (nbits >= 8 && op == C_RDSR && i >= 8)
        e = st[7 - (i - 8) % 8];
`endif
      if (care) check($sformatf("miso_bit%0d", i), rx_bits[i], e);
    end
    if (nbits >= 8) begin
      case (op)
        C_WREN: if (nbits == 8) m_wel = 1'b1;
        C_WRDI: if (nbits == 8) m_wel = 1'b0;
        C_WRITE: begin
          nb = (nbits >= 24) ? (nbits - 24) / 8 : 0;
          if (m_wel) begin
            for (int k = 0; k < nb; k++) begin
              d = 8'h00;
              for (int j = 0; j < 8; j++) d = {d[6:0], tx_bits[24+8*k+j]};
              a = (base + k) % DEPTH;
              m_mem[a] = d;
              m_known[a] = 1'b1;
            end
          end
          m_wel = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic run(input int nbits);
    spi_txn(nbits, 1'b0);
    model_txn(nbits);
    check("wel", {31'b0, wel}, {31'b0, m_wel});
  endtask

  task automatic do_wren();
    put_byte(0, C_WREN);
    run(8);
  endtask

  task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] v);
    bd_addr = a;
    repeat (2) @(negedge clk);
    v = bd_dout;
  endtask

  task automatic bd_model(input logic [AW-1:0] a);
    logic [7:0] v;
    bd_read(a, v);
    if (m_known[a]) check($sformatf("bd_%0h", a), v, m_mem[a]);
  endtask

  task automatic bd_lit(input logic [AW-1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bd_read(a, v);
    check($sformatf("bd_lit_%0h", a), v, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sel, nb;
    logic [7:0] op;
    logic [10:0] lo;
    logic [15:0] a16;

    m_wel = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_miso", {31'b0, spi_miso}, 32'd0);
    check("rst_wel", {31'b0, wel}, 32'd0);
    check("rst_bd", {24'b0, bd_dout}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Known region 0x7F0..0x01F (wraps)
    do_wren();
    check("wel_set", {31'b0, wel}, 32'd1);
    put_hdr(C_WRITE, 16'h07F0);
    for (int i = 0; i < 48; i++) put_byte(24 + 8*i, 8'(i*37 + 5));
    run(24 + 48*8);
    bd_model(11'h7F0);
    bd_model(11'h005);

    do_wren();
    put_hdr(C_WRITE, 16'h0123);
    put_byte(24, 8'hA5);
    run(32);
    bd_lit(11'h123, 8'hA5);
    check("wel_clr_write", {31'b0, wel}, 32'd0);

    put_hdr(C_WRITE, 16'h0010);
    put_byte(24, 8'h55);
    run(32);
    bd_lit(11'h010, 8'hA5);
    check("wel_stays0", {31'b0, wel}, 32'd0);

    do_wren();
    put_hdr(C_WRITE, 16'h07FF);
    put_byte(24, 8'h11);
    put_byte(32, 8'h22);
    run(40);
    put_hdr(C_READ, 16'h07FF);
    put_byte(24, 8'h00);
    put_byte(32, 8'h00);
    run(40);
    check("rd_wrap_b0", {24'b0, rx_byte(24)}, 32'h11);
    check("rd_wrap_b1", {24'b0, rx_byte(32)}, 32'h22);

    do_wren();
    put_hdr(C_WRITE, 16'h0041);
    put_byte(24, 8'h99);
    run(32);
    do_wren();
    put_hdr(C_WRITE, 16'h0040);
    put_byte(24, 8'h3C);
    put_byte(32, 8'hF8);
    run(37);
    bd_lit(11'h040, 8'h3C);
    bd_lit(11'h041, 8'h99);

    do_wren();
    put_byte(0, C_RDSR);
    put_byte(8, 8'h00);
    put_byte(16, 8'h00);
    run(24);
`ifdef SPI_FLASH_TARGET_RDSR_EN
    check("rdsr_b0", {24'b0, rx_byte(8)}, 32'h02);
    check("rdsr_b1", {24'b0, rx_byte(16)}, 32'h02);
`else
    check("rdsr_b0", {24'b0, rx_byte(8)}, 32'h00);
    check("rdsr_b1", {24'b0, rx_byte(16)}, 32'h00);
`endif
    put_byte(0, C_WRDI);
    run(8);
    check("wel_wrdi", {31'b0, wel}, 32'd0);

    // Reset 12 bits into a WRITE
    do_wren();
    put_hdr(C_WRITE, 16'h0041);
    spi_txn(12, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_wel = 1'b0;
    #(HALF);
    spi_cs = 1'b1;
    #(CS_GAP);
    check("wel_after_rst", {31'b0, wel}, 32'd0);
    bd_lit(11'h041, 8'h99);
    put_hdr(C_READ, 16'h07FF);
    run(40);
    check("rd_after_rst_b0", {24'b0, rx_byte(24)}, 32'h11);
    check("rd_after_rst_b1", {24'b0, rx_byte(32)}, 32'h22);

    for (int t = 0; t < 50; t++) begin
      sel = $urandom_range(0, 9);
      lo = 11'h7F0 + 11'($urandom_range(0, 47));
      a16 = {5'($urandom), lo};
      for (int i = 0; i < 512; i++) tx_bits[i] = 1'($urandom);
      if (sel <= 2) begin
        op = C_WREN;
        nb = ($urandom_range(0, 3) == 0) ? 8 + $urandom_range(1, 5) : 8;
      end else if (sel == 3) begin
        op = C_WRDI;
        nb = ($urandom_range(0, 3) == 0) ? 8 + $urandom_range(1, 5) : 8;
      end else if (sel <= 5) begin
        op = C_WRITE;
        nb = 24 + $urandom_range(0, 33);
      end else if (sel <= 7) begin
        op = C_READ;
        nb = 24 + $urandom_range(0, 33);
      end else if (sel == 8) begin
        op = C_RDSR;
        nb = 8 + $urandom_range(0, 20);
      end else begin
        op = 8'($urandom);
        nb = 8 + $urandom_range(0, 12);
      end
      put_hdr(op, a16);
      run(nb);
      bd_model(11'h7F0 + 11'($urandom_range(0, 47)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_target.md
SPI_FLASH_TARGET -- requirements
Module: spi_flash_target

Interface
REQ-001 Parameter: FLASH_ADDR_SZ, default 11, byte-address width of the internal array (2^FLASH_ADDR_SZ bytes).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 spi_clk  input  1  SPI clock from controller; asynchronous to clk; idles low (mode 0).
REQ-005 spi_cs  input  1  chip select, active low; asynchronous.
REQ-006 spi_mosi  input  1  controller-to-target serial data, MSB first.
REQ-007 spi_miso  output  1  target-to-controller serial data, MSB first; 0 when not driving.
REQ-008 bd_addr  input  FLASH_ADDR_SZ  backdoor read address.
REQ-009 bd_dout  output  8  backdoor read data; array[bd_addr] registered, 1-cycle latency.
REQ-010 wel  output  1  write-enable latch state.

Function
REQ-011 spi_clk, spi_cs, spi_mosi pass through 2-flop synchronizers; edges detected on synchronized values; clk SHALL be >= 4x spi_clk.
REQ-012 spi_mosi sampled on detected spi_clk rising edge; spi_miso updated on detected falling edge, within 3 clk of the pin edge.
REQ-013 spi_cs high (synchronized) forces state IDLE, clears bit counter, spi_miso=0, from any state.
REQ-014 States: IDLE, CMD, ADDR_HI, ADDR_LO, DATA_RD, DATA_WR, STATUS, IGNORE.
REQ-015 IDLE->CMD on spi_cs falling; CMD shifts 8 bits then decodes opcode.
REQ-016 0x06 WREN: -> IGNORE; wel set on spi_cs rising only if exactly 8 bits received.
REQ-017 0x04 WRDI: -> IGNORE; wel cleared on spi_cs rising if exactly 8 bits received.
REQ-018 0x03 READ and 0x02 WRITE: -> ADDR_HI -> ADDR_LO (8 bits each, 16-bit address); low FLASH_ADDR_SZ bits form byte pointer, upper bits ignored.
REQ-019 READ: array[ptr] fetched on 24th rising edge; its MSB driven on the following falling edge; bytes stream continuously, ptr increments after each 8th bit.
REQ-020 WRITE: each complete byte (8th rising edge) written to array[ptr] if wel=1, then ptr increments; wel=0 discards data.
REQ-021 ptr wraps from 2^FLASH_ADDR_SZ-1 to 0 in both READ and WRITE.
REQ-022 Partial byte at spi_cs rising discarded; completed bytes remain written.
REQ-023 Any WRITE command (0x02) terminated by spi_cs rising after >= 8 bits clears wel.
REQ-024 Unknown opcodes -> IGNORE: further bits ignored, spi_miso=0 until spi_cs rises.
REQ-025 Backdoor read SHALL not disturb SPI accesses; same-cycle SPI write and backdoor read of same address returns old data.

Reset
REQ-026 Reset: state IDLE, wel=0, ptr=0, counters 0, spi_miso=0, bd_dout=0, synchronizers to idle (spi_cs=1, spi_clk=0).
REQ-027 Array contents SHALL not be cleared by reset.
REQ-028 Reset mid-transaction aborts it; no array write for the in-flight byte; target resumes at next spi_cs falling edge.

Configuration
REQ-029 Macro SPI_FLASH_TARGET_RDSR_EN defined: opcode 0x05 -> STATUS, streams status byte {6'b0, wel, 1'b0} (WIP=0) repeatedly until spi_cs rises.
REQ-030 Macro undefined: 0x05 treated as unknown opcode (REQ-024); no status logic present.

Structure
REQ-031 Shared package holds opcode constants (WREN 0x06, WRDI 0x04, READ 0x03, WRITE 0x02, RDSR 0x05) and state encoding.
REQ-032 Sub-module spi_sync_edge: 2-flop synchronizer plus rising/falling edge detect, instantiated per SPI input.
REQ-033 Array implemented as inferred single-write, two-read register/RAM, no vendor primitives.

Verification
REQ-034 WREN, then WRITE addr 0x0123 data 0xA5 -> bd_addr=0x123 reads 0xA5; wel=0 after spi_cs rises.
REQ-035 WRITE addr 0x0010 data 0x55 with wel=0 -> array[0x010] unchanged; wel stays 0.
REQ-036 READ addr 0x07FF (FLASH_ADDR_SZ=11), 16 data clocks, array[0x7FF]=0x11, array[0x000]=0x22 -> MISO returns 0x11 then 0x22.
REQ-037 WREN then WRITE addr 0x0040 with 0x3C plus 5 extra bits -> array[0x040]=0x3C, array[0x041] unchanged.
REQ-038 RDSR_EN defined: WREN, then 0x05 with 16 data clocks -> MISO returns 0x02, 0x02; undefined -> 0x00, 0x00.
REQ-039 reset asserted after 12 bits of a WRITE -> no array change, wel=0, next READ transaction correct.
